// File: rtl/edge_frame_sequencer.sv
// edge_frame_sequencer: frame-timing controller for the Edge pixel pipeline.
// Pulls pixels from an upstream valid/ready source and emits the Pixel/Frame/Line
// stream with horizontal and vertical blanking. After the last line it waits out
// the Edge pipeline latency and then reports the completed frame.
//
// Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   Start, Continuous   frame start (taken in IDLE) and back-to-back mode (taken in DONE)
//   SrcPixel/SrcValid   upstream pixel data and its valid flag
//   SrcReady            combinational; high during ACTIVE slots
//   PixelOut/FrameOut/LineOut  registered stream to Edge, one cycle after each slot
//   Busy, Done          busy status and one-cycle frame-complete pulse
//   Underrun            sticky flag; the source missed an ACTIVE slot
//   FrameCount          count of completed frames (wraps)
module edge_frame_sequencer #(
    parameter int unsigned WIDTH    = 640,
    parameter int unsigned HEIGHT   = 480,
    parameter int unsigned HBLANK   = 16,
    parameter int unsigned VBLANK   = 4,
    parameter int unsigned PIPE_LAT = 9
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Continuous,
    input  logic [7:0]  SrcPixel,
    input  logic        SrcValid,
    output logic        SrcReady,
    output logic [7:0]  PixelOut,
    output logic        FrameOut,
    output logic        LineOut,
    output logic        Busy,
    output logic        Done,
    output logic        Underrun,
    output logic [15:0] FrameCount
);

    localparam int unsigned PIX_W = 8;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned XW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int unsigned YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned BMAX_HV = (HBLANK > VBLANK) ? HBLANK : VBLANK;
    localparam int unsigned BMAX    = (BMAX_HV > PIPE_LAT) ? BMAX_HV : PIPE_LAT;
    localparam int unsigned BW    = (BMAX > 1) ? $clog2(BMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_HBLANK,
        S_VBLANK,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [BW-1:0]      b_q, b_d;
    logic [PIX_W-1:0]   pixel_q, pixel_d;
    logic               frame_q, frame_d;
    logic               line_q, line_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               underrun_q, underrun_d;
    logic [CNT_W-1:0]   frame_count_q, frame_count_d;

    // State and output registers; reset overrides everything, including mid-frame.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            b_q           <= '0;
            pixel_q       <= '0;
            frame_q       <= 1'b0;
            line_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            underrun_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            b_q           <= b_d;
            pixel_q       <= pixel_d;
            frame_q       <= frame_d;
            line_q        <= line_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            underrun_q    <= underrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Next-state, counters and registered stream outputs.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        b_d           = b_q;
        pixel_d       = '0;
        frame_d       = 1'b0;
        line_d        = 1'b0;
        done_d        = 1'b0;
        underrun_d    = underrun_q;
        frame_count_d = frame_count_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d    = S_ACTIVE;
                    x_d        = '0;
                    y_d        = '0;
                    b_d        = '0;
                    underrun_d = 1'b0;
                end
            end
            S_ACTIVE: begin
                // Edge cannot stall: a missing pixel becomes a zero slot and timing moves on.
                pixel_d = SrcValid ? SrcPixel : '0;
                frame_d = (x_q == '0) && (y_q == '0);
                line_d  = (x_q == '0);
                if (!SrcValid) begin
                    underrun_d = 1'b1;
                end
                if (x_q == XW'(WIDTH - 1)) begin
                    x_d     = '0;
                    b_d     = '0;
                    state_d = (y_q == YW'(HEIGHT - 1)) ? S_VBLANK : S_HBLANK;
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            S_HBLANK: begin
                if (b_q == BW'(HBLANK - 1)) begin
                    state_d = S_ACTIVE;
                    b_d     = '0;
                    y_d     = y_q + YW'(1);
                end else begin
                    b_d = b_q + BW'(1);
                end
            end
            S_VBLANK: begin
                if (b_q == BW'(VBLANK - 1)) begin
                    state_d = S_DRAIN;
                    b_d     = '0;
                end else begin
                    b_d = b_q + BW'(1);
                end
            end
            S_DRAIN: begin
                // Count and flag are updated on entry so they line up with the DONE cycle.
                if (b_q == BW'(PIPE_LAT - 1)) begin
                    state_d       = S_DONE;
                    b_d           = '0;
                    done_d        = 1'b1;
                    frame_count_d = frame_count_q + CNT_W'(1);
                end else begin
                    b_d = b_q + BW'(1);
                end
            end
            S_DONE: begin
                if (Continuous) begin
                    state_d = S_ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign SrcReady   = (state_q == S_ACTIVE);
    assign PixelOut   = pixel_q;
    assign FrameOut   = frame_q;
    assign LineOut    = line_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Underrun   = underrun_q;
    assign FrameCount = frame_count_q;

endmodule

// File: tb/tb_edge_frame_sequencer.sv
// Directed bench for edge_frame_sequencer with a 4x2 frame, HBLANK=2, VBLANK=1, PIPE_LAT=9.
// Cycle 0 of each sequence is an IDLE cycle in which Start is driven.
module tb_edge_frame_sequencer;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned HB = 2;
    localparam int unsigned VB = 1;
    localparam int unsigned PL = 9;
    // Continuous frame period: 4*2 + 2*1 + 1 + 9 + 1
    localparam int PER = 21;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Continuous = 1'b0;
    logic [7:0]  SrcPixel = 8'h00;
    logic        SrcValid = 1'b0;
    logic        SrcReady;
    logic [7:0]  PixelOut;
    logic        FrameOut;
    logic        LineOut;
    logic        Busy;
    logic        Done;
    logic        Underrun;
    logic [15:0] FrameCount;

    int n_cmp = 0;
    int n_mis = 0;

    edge_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VBLANK(VB), .PIPE_LAT(PL)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Continuous(Continuous),
        .SrcPixel(SrcPixel), .SrcValid(SrcValid), .SrcReady(SrcReady),
        .PixelOut(PixelOut), .FrameOut(FrameOut), .LineOut(LineOut),
        .Busy(Busy), .Done(Done), .Underrun(Underrun), .FrameCount(FrameCount)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag, input int c);
        chk({tag, "_ready"}, c, 16'(SrcReady), 16'h0);
        chk({tag, "_busy"},  c, 16'(Busy), 16'h0);
        chk({tag, "_pixel"}, c, 16'(PixelOut), 16'h0);
        chk({tag, "_frame"}, c, 16'(FrameOut), 16'h0);
        chk({tag, "_line"},  c, 16'(LineOut), 16'h0);
        chk({tag, "_done"},  c, 16'(Done), 16'h0);
        chk({tag, "_unr"},   c, 16'(Underrun), 16'h0);
        chk({tag, "_fc"},    c, FrameCount, 16'h0);
    endtask

    // Slot position of cycle c: ACTIVE cycles are offsets 0-3 (line 0) and 6-9 (line 1)
    // within each 21-cycle frame that starts at cycle 1.
    function automatic bit slot(input int c, input int nfr, output int x, output int y, output int f);
        int r;
        x = 0; y = 0; f = 0;
        if (c < 1) return 1'b0;
        f = (c - 1) / PER;
        r = (c - 1) % PER;
        if (f >= nfr) return 1'b0;
        if (r < 4) begin x = r; return 1'b1; end
        if (r >= 6 && r < 10) begin x = r - 6; y = 1; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic logic [7:0] ramp(input int x, input int y, input int f);
        return 8'(1 + 4 * y + x + 16 * f);
    endfunction

    // Runs nfr frames starting from IDLE and checks every output on every cycle.
    task automatic run_seq(input int nfr, input int st_a, input int st_b, input int inval,
                           input logic prev_unr, input logic [15:0] fc0);
        int x, y, f, px, py, pf;
        bit a, pa, done_e;
        logic [7:0] exp_pix;
        logic [15:0] fc;
        logic exp_unr;
        fc = fc0;
        for (int c = 0; c <= PER * nfr + 1; c++) begin
            a  = slot(c, nfr, x, y, f);
            pa = slot(c - 1, nfr, px, py, pf);
            Start      = (c == 0) || (c == st_a) || (c == st_b);
            Continuous = (c < PER * (nfr - 1) + 10);
            SrcValid   = (c != inval);
            SrcPixel   = a ? ramp(x, y, f) : 8'($urandom);
            exp_pix    = (pa && (c - 1) != inval) ? ramp(px, py, pf) : 8'h00;
            done_e     = (c >= 1) && (c <= PER * nfr) && ((c - 1) % PER == 20);
            exp_unr    = (c == 0) ? prev_unr : (inval >= 1 && c > inval);
            chk("src_ready", c, 16'(SrcReady), 16'(a));
            chk("busy",      c, 16'(Busy), 16'(c >= 1 && c <= PER * nfr));
            chk("pixel_out", c, 16'(PixelOut), 16'(exp_pix));
            chk("frame_out", c, 16'(FrameOut), 16'(pa && px == 0 && py == 0));
            chk("line_out",  c, 16'(LineOut), 16'(pa && px == 0));
            chk("done",      c, 16'(Done), 16'(done_e));
            chk("underrun",  c, 16'(Underrun), 16'(exp_unr));
            if (!done_e) begin
                chk("frame_count", c, FrameCount, fc);
            end else begin
                fc = fc + 16'd1;
            end
            tick();
        end
    endtask

    initial begin
        // Reset held, then released into IDLE.
        Reset = 1'b1;
        repeat (3) tick();
        chk_idle_zero("rst_held", 0);
        Reset = 1'b0;
        tick();
        chk_idle_zero("rst_idle", 0);

        // Basic frame, ramp 1..8, source always valid.
        run_seq(1, -1, -1, -1, 1'b0, 16'd0);
        // Underrun: SrcValid low in cycle 3 only.
        run_seq(1, -1, -1, 3, 1'b0, 16'd1);
        // Start pulses at cycles 5 and 15 are ignored; this Start clears Underrun.
        run_seq(1, 5, 15, -1, 1'b1, 16'd2);
        // Two back-to-back frames in continuous mode.
        run_seq(2, -1, -1, -1, 1'b0, 16'd3);

        // Reset at cycle 8 of a frame, restart at cycle 10.
        for (int c = 0; c <= 12; c++) begin
            Start      = (c == 0) || (c == 10);
            Reset      = (c == 8);
            Continuous = 1'b0;
            SrcValid   = 1'b1;
            SrcPixel   = 8'(8'h40 + c);
            if (c == 8) begin
                chk("pre_rst_busy", c, 16'(Busy), 16'h1);
                chk("pre_rst_fc",   c, FrameCount, 16'd5);
                chk("pre_rst_pix",  c, 16'(PixelOut), 16'h47);
            end
            if (c == 9) chk_idle_zero("mid_rst", c);
            if (c == 11) begin
                chk("rst_restart_ready", c, 16'(SrcReady), 16'h1);
                chk("rst_restart_frame", c, 16'(FrameOut), 16'h0);
            end
            if (c == 12) begin
                chk("rst_restart_frame", c, 16'(FrameOut), 16'h1);
                chk("rst_restart_line",  c, 16'(LineOut), 16'h1);
                chk("rst_restart_pix",   c, 16'(PixelOut), 16'h4b);
                chk("rst_restart_busy",  c, 16'(Busy), 16'h1);
            end
            tick();
        end
        Reset = 1'b1;
        Start = 1'b0;
        repeat (2) tick();
        Reset = 1'b0;
        tick();

        // FrameCount wrap: preload 0xFFFF while idle, then one frame.
        force dut.frame_count_q = 16'hFFFF;
        tick();
        release dut.frame_count_q;
        run_seq(1, -1, -1, -1, 1'b0, 16'hFFFF);
        chk("wrap_final", 0, FrameCount, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
